// File: rtl/cordic_byte_io.sv
// cordic_byte_io: byte-serial host front end for the iterative CORDIC core.
// Collects a 16-bit angle from two host bytes (low byte first), fires a
// one-cycle start to the core, captures the cos/sin results on completion
// and streams them back as four bytes: cos[7:0], cos[15:8], sin[7:0], sin[15:8].
//
// Optional feature: define CORDIC_IO_WATCHDOG_EN to abort a BUSY wait that
// lasts TIMEOUT_CYCLES cycles without core_done (returns to IDLE, sets err).
//
// Handshake: in_stb, rd_stb, clr_err and core_done are single-cycle pulses
// sampled on the rising clock edge. out_valid is a level that is high exactly
// while a result byte sits on out_data; each rd_stb acknowledges the byte
// currently presented and the next byte appears on the following cycle.
// The internal fsm_state signal carries the FSM state for debug/checkers.
module cordic_byte_io #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_stb,
    input  logic        rd_stb,
    input  logic        clr_err,
    output logic        core_start,
    output logic [15:0] core_angle,
    input  logic        core_done,
    input  logic [15:0] core_cos,
    input  logic [15:0] core_sin,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_START   = 3'd2,
        S_BUSY    = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t      fsm_state;
    state_t      state_next;
    logic [31:0] result;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_next;
    logic        err_set;
    logic        timeout;

    assign byte_idx_next = byte_idx + 2'd1;

    // Byte lane selection of the captured {sin, cos} result.
    function automatic logic [7:0] pick_byte(input logic [31:0] r, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = r[7:0];
            2'd1:    b = r[15:8];
            2'd2:    b = r[23:16];
            default: b = r[31:24];
        endcase
        return b;
    endfunction

`ifdef CORDIC_IO_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt;

    // Watchdog counter: zero outside BUSY, counts each BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 8'd0;
        end else if (fsm_state != S_BUSY) begin
            wd_cnt <= 8'd0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // Timeout fires in the BUSY cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout = (fsm_state == S_BUSY) && (wd_cnt == WD_LAST);
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state <= S_IDLE;
        end else begin
            fsm_state <= state_next;
        end
    end

    // Next-state decode, state-derived outputs and error-set events.
    always_comb begin
        state_next = fsm_state;
        core_start = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        err_set    = 1'b0;
        case (fsm_state)
            S_IDLE: begin
                if (in_stb) state_next = S_LOAD_HI;
                if (rd_stb) err_set = 1'b1;
            end
            S_LOAD_HI: begin
                busy = 1'b1;
                if (in_stb) state_next = S_START;
                if (rd_stb) err_set = 1'b1;
            end
            S_START: begin
                busy       = 1'b1;
                core_start = 1'b1;
                state_next = S_BUSY;
                if (in_stb || rd_stb) err_set = 1'b1;
            end
            S_BUSY: begin
                busy = 1'b1;
                if (in_stb || rd_stb) err_set = 1'b1;
                // A completion in the timeout cycle takes priority.
                if (core_done) begin
                    state_next = S_OUT;
                end else if (timeout) begin
                    state_next = S_IDLE;
                    err_set    = 1'b1;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (in_stb) err_set = 1'b1;
                if (rd_stb && (byte_idx == 2'd3)) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sticky error flag; a set event in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

    // Angle assembly: low byte in IDLE, high byte in LOAD_HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_angle <= 16'h0000;
        end else if (in_stb && (fsm_state == S_IDLE)) begin
            core_angle[7:0] <= in_data;
        end else if (in_stb && (fsm_state == S_LOAD_HI)) begin
            core_angle[15:8] <= in_data;
        end
    end

    // Result capture and the registered byte mux feeding out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= 32'h0;
            byte_idx <= 2'd0;
            out_data <= 8'h00;
        end else if ((fsm_state == S_BUSY) && core_done) begin
            result   <= {core_sin, core_cos};
            byte_idx <= 2'd0;
            out_data <= core_cos[7:0];
        end else if ((fsm_state == S_OUT) && rd_stb) begin
            if (byte_idx == 2'd3) begin
                // Last byte consumed: out_data idles at zero outside OUT.
                byte_idx <= 2'd0;
                out_data <= 8'h00;
            end else begin
                byte_idx <= byte_idx_next;
                out_data <= pick_byte(result, byte_idx_next);
            end
        end
    end

endmodule

// File: tb/tb_cordic_byte_io.sv
// Bench for cordic_byte_io: core stub, transaction-level reference model,
// per-cycle compare process and directed scenarios with literal expectations.
// Build with +define+CORDIC_IO_WATCHDOG_EN to exercise the watchdog.
module tb_cordic_byte_io;

    localparam int TO = 8;
`ifdef CORDIC_IO_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif
    localparam logic [15:0] STUB_COS = 16'h1234;
    localparam logic [15:0] STUB_SIN = 16'hABCD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data = 8'h00;
    logic        in_stb = 1'b0;
    logic        rd_stb = 1'b0;
    logic        clr_err = 1'b0;
    logic        core_start;
    logic [15:0] core_angle;
    logic        core_done;
    logic [15:0] core_cos = STUB_COS;
    logic [15:0] core_sin = STUB_SIN;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    cordic_byte_io #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_stb     (in_stb),
        .rd_stb     (rd_stb),
        .clr_err    (clr_err),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_done  (core_done),
        .core_cos   (core_cos),
        .core_sin   (core_sin),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .err        (err)
    );

    // Clock.
    always #5 clk = ~clk;

    // Core stub: completion pulse 16 cycles after core_start, plus an override.
    int   stub_cnt = 0;
    logic stub_done = 1'b0;
    bit   stub_en = 1'b1;
    logic force_done = 1'b0;
    assign core_done = stub_done | force_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            stub_cnt  = 0;
            stub_done = 1'b0;
        end else begin
            stub_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt = stub_cnt - 1;
                if (stub_cnt == 0) stub_done = 1'b1;
            end
            if (core_start && stub_en) stub_cnt = 16;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. m_phase: 0 idle, 1 low byte held, 2 start, 3 waiting
    // for the core, 4 results being read. Results are a 32-bit word read
    // out byte by byte with a running offset.
    int          m_phase = 0;
    logic [15:0] m_angle = 16'h0;
    logic [31:0] m_res = 32'h0;
    int          m_idx = 0;
    logic        m_err = 1'b0;
    int          m_wait = 0;

    function automatic bit m_fire(input int ph, input int w, input logic done);
        return WD_ON && (ph == 3) && !done && (w + 1 == TO);
    endfunction

    function automatic bit m_err_event(input int ph, input logic wr, input logic rd, input bit fire);
        return (wr && ph >= 2) || (rd && ph != 4) || fire;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_angle <= 16'h0;
            m_res   <= 32'h0;
            m_idx   <= 0;
            m_err   <= 1'b0;
            m_wait  <= 0;
        end else begin
            if (m_err_event(m_phase, in_stb, rd_stb, m_fire(m_phase, m_wait, core_done)))
                m_err <= 1'b1;
            else if (clr_err)
                m_err <= 1'b0;
            case (m_phase)
                0: if (in_stb) begin m_angle[7:0] <= in_data; m_phase <= 1; end
                1: if (in_stb) begin m_angle[15:8] <= in_data; m_phase <= 2; end
                2: begin m_phase <= 3; m_wait <= 0; end
                3: begin
                    if (core_done) begin
                        m_res   <= {core_sin, core_cos};
                        m_idx   <= 0;
                        m_phase <= 4;
                    end else if (m_fire(m_phase, m_wait, core_done)) begin
                        m_phase <= 0;
                    end else begin
                        m_wait <= m_wait + 1;
                    end
                end
                default: if (rd_stb) begin
                    if (m_idx == 3) begin m_phase <= 0; m_idx <= 0; end
                    else m_idx <= m_idx + 1;
                end
            endcase
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 3));
        check("core_start", 32'(core_start), 32'(m_phase == 2));
        check("out_valid", 32'(out_valid), 32'(m_phase == 4));
        check("out_data", 32'(out_data), (m_phase == 4) ? 32'(m_res[8*m_idx +: 8]) : 32'h0);
        check("core_angle", 32'(core_angle), 32'(m_angle));
        check("err", 32'(err), 32'(m_err));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        in_data = b;
        in_stb  = 1'b1;
        tick();
        in_stb  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 32'h1);
    endtask

    task automatic read_byte(input logic [7:0] exp);
        check("read_byte", 32'(out_data), 32'(exp));
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
    endtask

    task automatic read_all();
        read_byte(8'h34);
        read_byte(8'h12);
        read_byte(8'hCD);
        read_byte(8'hAB);
        check("valid_after_last", 32'(out_valid), 32'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_angle", 32'(core_angle), 32'h0);
        rst_n = 1'b1;
        tick();

        // Normal transfer.
        write_byte(8'h00);
        check("busy_after_lo", 32'(busy), 32'h1);
        write_byte(8'h20);
        check("angle_2000", 32'(core_angle), 32'h2000);
        check("start_pulse", 32'(core_start), 32'h1);
        tick();
        check("start_once", 32'(core_start), 32'h0);
        wait_valid();
        check("busy_in_out", 32'(busy), 32'h0);
        read_all();
        check("err_clean", 32'(err), 32'h0);

        // Write while busy, accepted straight after the last read.
        write_byte(8'h00);
        write_byte(8'h20);
        repeat (3) tick();
        write_byte(8'hFF);
        check("busy_write_angle", 32'(core_angle), 32'h2000);
        check("busy_write_err", 32'(err), 32'h1);
        pulse_clr();
        check("clr_err", 32'(err), 32'h0);
        wait_valid();
        read_all();

        // Spurious read in IDLE, then set/clear collision.
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
        check("spur_rd_err", 32'(err), 32'h1);
        check("spur_rd_valid", 32'(out_valid), 32'h0);
        pulse_clr();
        clr_err = 1'b1;
        rd_stb  = 1'b1;
        tick();
        clr_err = 1'b0;
        rd_stb  = 1'b0;
        check("collision_err", 32'(err), 32'h1);
        pulse_clr();

        // Stray completion in IDLE is ignored silently.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("stray_done_err", 32'(err), 32'h0);
        check("stray_done_valid", 32'(out_valid), 32'h0);

        // Simultaneous write and read while in OUT.
        write_byte(8'h00);
        write_byte(8'h40);
        wait_valid();
        check("out_first", 32'(out_data), 32'h34);
        in_data = 8'h77;
        in_stb  = 1'b1;
        rd_stb  = 1'b1;
        tick();
        in_stb  = 1'b0;
        rd_stb  = 1'b0;
        check("both_err", 32'(err), 32'h1);
        check("both_next", 32'(out_data), 32'h12);
        check("both_angle", 32'(core_angle), 32'h4000);
        read_byte(8'h12);
        read_byte(8'hCD);
        read_byte(8'hAB);
        pulse_clr();

        // Reset in OUT after two reads, with err set beforehand.
        write_byte(8'h00);
        write_byte(8'h20);
        wait_valid();
        read_byte(8'h34);
        read_byte(8'h12);
        in_stb = 1'b1;
        tick();
        in_stb = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_start", 32'(core_start), 32'h0);
        check("arst_angle", 32'(core_angle), 32'h0);
        check("arst_data", 32'(out_data), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_err", 32'(err), 32'h0);
        repeat (2) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        write_byte(8'h01);
        write_byte(8'h00);
        check("angle_0001", 32'(core_angle), 32'h0001);
        wait_valid();
        read_all();

        // Core never completes.
        stub_en = 1'b0;
        write_byte(8'h00);
        write_byte(8'h20);
`ifdef CORDIC_IO_WATCHDOG_EN
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("wd_cycles", 32'(n), 32'd9);
        check("wd_err", 32'(err), 32'h1);
        check("wd_busy", 32'(busy), 32'h0);
        check("wd_valid", 32'(out_valid), 32'h0);
`else
        n = 0;
        repeat (100) begin
            tick();
            if (busy) n++;
        end
        check("nowd_busy_cycles", 32'(n), 32'd100);
        check("nowd_err", 32'(err), 32'h0);
`endif
        stub_en = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
